// File: rtl/spi_host_cmd_ctrl_if.sv
// Command-side handshake and SPI pin bundle for the SPI host command controller.
interface spi_host_cmd_ctrl_if;
    logic        start_i;
    logic [7:0]  cmd_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        spi_sck_o;
    logic        spi_csn_o;
    logic        spi_mosi_o;
    logic        spi_miso_i;

    // Requesting side: issues commands and supplies the device's MISO line
    modport master (
        output start_i, cmd_i, addr_i, wdata_i, spi_miso_i,
        input  busy_o, done_o, err_o, rdata_o, spi_sck_o, spi_csn_o, spi_mosi_o
    );

    // Controller side
    modport slave (
        input  start_i, cmd_i, addr_i, wdata_i, spi_miso_i,
        output busy_o, done_o, err_o, rdata_o, spi_sck_o, spi_csn_o, spi_mosi_o
    );
endinterface

// File: rtl/spi_host_cmd_ctrl.sv
// SPI host command controller: turns one opcode/address/data request into a
// mode-0 SPI transaction (command, optional address, dummy and data phases).
module spi_host_cmd_ctrl #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    spi_host_cmd_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, CS_SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, CS_HOLD, DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_REG_WR, OP_REG_RD, OP_MEM_WR, OP_MEM_RD
    } op_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    state_t      state;
    op_t         op;
    op_t         dec_op;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rx_shift;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        bad_cmd;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        sck_q;
    logic        csn_q;
    logic        mosi_q;
    logic        div_tick;
    logic        is_mem;
    logic        is_read;
    logic [4:0]  nxt_idx;
    logic        nxt_bit;

    assign div_tick = (div_cnt == DIV_LAST);
    assign is_mem   = (op == OP_MEM_WR) || (op == OP_MEM_RD);
    assign is_read  = (op == OP_REG_RD) || (op == OP_MEM_RD);
    assign nxt_idx  = 5'(bit_cnt - 6'd1);

    // Classify the incoming opcode; anything outside the table is rejected
    always_comb begin
        dec_op = OP_NONE;
        case (bus.cmd_i)
            8'h01, 8'h11, 8'h20, 8'h30: dec_op = OP_REG_WR;
            8'h05, 8'h07, 8'h21, 8'h31: dec_op = OP_REG_RD;
            8'h02:                      dec_op = OP_MEM_WR;
            8'h0B:                      dec_op = OP_MEM_RD;
            default:                    dec_op = OP_NONE;
        endcase
    end

    // Bit driven onto MOSI at the next falling SCK edge inside the current phase
    always_comb begin
        nxt_bit = 1'b0;
        case (state)
            CMD:     nxt_bit = cmd_q[nxt_idx[2:0]];
            ADDR:    nxt_bit = addr_q[nxt_idx];
            WDATA:   nxt_bit = wdata_q[nxt_idx];
            default: nxt_bit = 1'b0;
        endcase
    end

    // Transaction FSM with registered SPI pins and handshake outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            op       <= OP_NONE;
            cmd_q    <= 8'h00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rx_shift <= 32'h0;
            div_cnt  <= 8'h00;
            bit_cnt  <= 6'd0;
            bad_cmd  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            sck_q    <= 1'b0;
            csn_q    <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        cmd_q    <= bus.cmd_i;
                        addr_q   <= bus.addr_i;
                        wdata_q  <= bus.wdata_i;
                        op       <= dec_op;
                        rx_shift <= 32'h0;
                        div_cnt  <= 8'h00;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        if (dec_op == OP_NONE) begin
                            bad_cmd <= 1'b1;
                            state   <= CS_HOLD;
                        end else begin
                            bad_cmd <= 1'b0;
                            csn_q   <= 1'b0;
                            mosi_q  <= bus.cmd_i[7];
                            state   <= CS_SETUP;
                        end
                    end
                end
                CS_SETUP: begin
                    if (div_tick) begin
                        div_cnt <= 8'h00;
                        bit_cnt <= 6'd7;
                        state   <= CMD;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                CMD, ADDR, DUMMY, WDATA, RDATA: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'h00;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state == RDATA) begin
                                rx_shift <= {rx_shift[30:0], bus.spi_miso_i};
                            end
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_cnt != 6'd0) begin
                                bit_cnt <= bit_cnt - 6'd1;
                                mosi_q  <= nxt_bit;
                            end else begin
                                case (state)
                                    CMD: begin
                                        if (is_mem) begin
                                            state   <= ADDR;
                                            bit_cnt <= 6'd31;
                                            mosi_q  <= addr_q[31];
                                        end else if (op == OP_REG_WR) begin
                                            state   <= WDATA;
                                            bit_cnt <= 6'd7;
                                            mosi_q  <= wdata_q[7];
                                        end else begin
                                            state   <= RDATA;
                                            bit_cnt <= 6'd7;
                                            mosi_q  <= 1'b0;
                                        end
                                    end
                                    ADDR: begin
                                        if (op == OP_MEM_WR) begin
                                            state   <= WDATA;
                                            bit_cnt <= 6'd31;
                                            mosi_q  <= wdata_q[31];
                                        end else begin
                                            state   <= DUMMY;
                                            bit_cnt <= DUMMY_LAST;
                                            mosi_q  <= 1'b0;
                                        end
                                    end
                                    DUMMY: begin
                                        state   <= RDATA;
                                        bit_cnt <= 6'd31;
                                        mosi_q  <= 1'b0;
                                    end
                                    default: begin
                                        state   <= CS_HOLD;
                                        bit_cnt <= 6'd0;
                                        mosi_q  <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (bad_cmd || div_tick) begin
                        div_cnt <= 8'h00;
                        csn_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= bad_cmd;
                        state   <= DONE;
                        if (is_read) begin
                            rdata_q <= rx_shift;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.spi_sck_o  = sck_q;
    assign bus.spi_csn_o  = csn_q;
    assign bus.spi_mosi_o = mosi_q;
endmodule

// File: tb/tb_spi_host_cmd_ctrl.sv
// Self-checking bench for spi_host_cmd_ctrl: directed and random commands
// against a behavioural bit-stream model and an SPI device model.
module tb_spi_host_cmd_ctrl;
    localparam int D      = 2;
    localparam int DUMMY  = 32;
    localparam int D1     = 1;
    localparam int DUMMY1 = 4;
    localparam int LIMIT  = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_host_cmd_ctrl_if bus();
    spi_host_cmd_ctrl_if bus1();

    spi_host_cmd_ctrl #(.CLK_DIV(D), .DUMMY_CYCLES(DUMMY)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    spi_host_cmd_ctrl #(.CLK_DIV(D1), .DUMMY_CYCLES(DUMMY1)) dut_d1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    int rise_cnt      = 0;
    int csn_low_total = 0;
    int done_total    = 0;
    int proto_err     = 0;
    logic mosi_log[$];

    int done1_total = 0;
    int csn1_falls  = 0;
    logic csn1_prev = 1'b1;

    int dev_pre  = 0;
    int dev_n    = 0;
    int dev_base = 0;
    int dev_k;
    int dev_idx;
    logic [31:0] dev_resp = 32'h0;
    logic [31:0] noise    = 32'h0;

    logic [31:0] exp_rdata = 32'h0;

    // Device model: serves the response MSB first during the read window, noise elsewhere
    assign dev_k   = rise_cnt - dev_base;
    assign dev_idx = dev_n - 1 - (dev_k - dev_pre);
    assign bus.spi_miso_i  = (dev_k >= dev_pre && dev_k < dev_pre + dev_n) ?
                             dev_resp[dev_idx[4:0]] : noise[dev_k[4:0]];
    assign bus1.spi_miso_i = 1'b0;

    // Capture MOSI on every rising SCK edge of the main controller
    always @(posedge bus.spi_sck_o) begin
        mosi_log.push_back(bus.spi_mosi_o);
        rise_cnt++;
    end

    // Cycle-level counters for chip select, done pulses and SCK-without-CS
    always @(negedge clk) begin
        if (!bus.spi_csn_o) csn_low_total++;
        if (bus.done_o) done_total++;
        if (bus.spi_csn_o && bus.spi_sck_o) proto_err++;
        if (bus1.done_o) done1_total++;
        if (!bus1.spi_csn_o && csn1_prev) csn1_falls++;
        csn1_prev = bus1.spi_csn_o;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // One command on the main controller, checked against the opcode-table model
    task automatic applyStimulus(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] resp);
        logic exp_bits[$];
        bit   legal = 1'b1;
        bit   rd    = 1'b0;
        int   rise0, low0, mosi0, waits, mism, exp_low, exp_lat;
        exp_bits = {};
        for (int i = 7; i >= 0; i--) exp_bits.push_back(cmd[i]);
        dev_pre = 0;
        dev_n   = 0;
        case (cmd)
            8'h01, 8'h11, 8'h20, 8'h30: begin
                for (int i = 7; i >= 0; i--) exp_bits.push_back(wdata[i]);
            end
            8'h05, 8'h07, 8'h21, 8'h31: begin
                for (int i = 0; i < 8; i++) exp_bits.push_back(1'b0);
                rd = 1'b1; dev_pre = 8; dev_n = 8;
            end
            8'h02: begin
                for (int i = 31; i >= 0; i--) exp_bits.push_back(addr[i]);
                for (int i = 31; i >= 0; i--) exp_bits.push_back(wdata[i]);
            end
            8'h0B: begin
                for (int i = 31; i >= 0; i--) exp_bits.push_back(addr[i]);
                for (int i = 0; i < DUMMY + 32; i++) exp_bits.push_back(1'b0);
                rd = 1'b1; dev_pre = 40 + DUMMY; dev_n = 32;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) exp_bits = {};
        exp_low = legal ? (2 * exp_bits.size() + 2) * D : 0;
        exp_lat = legal ? exp_low + 1 : 2;

        dev_resp = resp;
        noise    = $urandom;
        dev_base = rise_cnt;
        rise0    = rise_cnt;
        low0     = csn_low_total;
        mosi0    = mosi_log.size();

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.cmd_i   = cmd;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        @(negedge clk);
        bus.start_i = 1'b0;
        waits = 1;
        checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        if (legal) checkOutput({tag, "_errclr"}, 32'(bus.err_o), 32'd0);
        while (bus.done_o !== 1'b1 && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        checkOutput({tag, "_done"}, 32'(bus.done_o), 32'd1);
        checkOutput({tag, "_latency"}, 32'(waits), 32'(exp_lat));
        if (legal && rd) exp_rdata = (cmd == 8'h0B) ? resp : {24'h0, resp[7:0]};
        checkOutput({tag, "_err"}, 32'(bus.err_o), 32'(!legal));
        checkOutput({tag, "_rdata"}, bus.rdata_o, exp_rdata);
        checkOutput({tag, "_csnlow"}, 32'(csn_low_total - low0), 32'(exp_low));
        checkOutput({tag, "_rises"}, 32'(rise_cnt - rise0), 32'(exp_bits.size()));
        if (!legal) checkOutput({tag, "_busydone"}, 32'(bus.busy_o), 32'd0);
        mism = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            if (mosi0 + i >= mosi_log.size()) mism++;
            else if (mosi_log[mosi0 + i] !== exp_bits[i]) mism++;
        end
        checkOutput({tag, "_mosi"}, 32'(mism), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(bus.done_o), 32'd0);
        checkOutput({tag, "_errhold"}, 32'(bus.err_o), 32'(!legal));
    endtask

    // Reset pulse in the address phase of a memory write aborts it silently
    task automatic resetMidAddr();
        int rise0, waits, done0, low0;
        rise0 = rise_cnt;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.cmd_i   = 8'h02;
        bus.addr_i  = $urandom;
        bus.wdata_i = $urandom;
        @(negedge clk);
        bus.start_i = 1'b0;
        waits = 0;
        while (rise_cnt - rise0 < 12 && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("rst_reach_addr", 32'(rise_cnt - rise0 >= 12), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_rdata = 32'h0;
        checkOutput("rst_csn",   32'(bus.spi_csn_o),  32'd1);
        checkOutput("rst_sck",   32'(bus.spi_sck_o),  32'd0);
        checkOutput("rst_mosi",  32'(bus.spi_mosi_o), 32'd0);
        checkOutput("rst_busy",  32'(bus.busy_o),     32'd0);
        checkOutput("rst_done",  32'(bus.done_o),     32'd0);
        checkOutput("rst_err",   32'(bus.err_o),      32'd0);
        checkOutput("rst_rdata", bus.rdata_o,         32'h0);
        rst_n = 1'b1;
        done0 = done_total;
        low0  = csn_low_total;
        repeat (40) @(negedge clk);
        checkOutput("rst_nodone", 32'(done_total - done0), 32'd0);
        checkOutput("rst_csnidle", 32'(csn_low_total - low0), 32'd0);
    endtask

    // start_i held high on the D=1 instance: one transaction per IDLE sample
    task automatic heldStart();
        int waits, done0, falls0;
        done0  = done1_total;
        falls0 = csn1_falls;
        @(negedge clk);
        bus1.start_i = 1'b1;
        bus1.cmd_i   = 8'h02;
        bus1.addr_i  = $urandom;
        bus1.wdata_i = $urandom;
        waits = 0;
        @(negedge clk);
        waits++;
        while (bus1.done_o !== 1'b1 && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("held_done", 32'(bus1.done_o), 32'd1);
        checkOutput("held_latency", 32'(waits), 32'((2 * 72 + 2) * D1 + 1));
        @(negedge clk);
        bus1.start_i = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("held_onedone", 32'(done1_total - done0), 32'd1);
        checkOutput("held_onecs", 32'(csn1_falls - falls0), 32'd1);
        @(negedge clk);
        bus1.start_i = 1'b1;
        bus1.cmd_i   = 8'h01;
        @(negedge clk);
        bus1.start_i = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("held_second_done", 32'(done1_total - done0), 32'd2);
        checkOutput("held_second_cs", 32'(csn1_falls - falls0), 32'd2);
    endtask

    logic [7:0] legal_ops [10] = '{8'h01, 8'h11, 8'h20, 8'h30, 8'h05, 8'h07, 8'h21, 8'h31, 8'h02, 8'h0B};
    logic [7:0] bad_ops   [6]  = '{8'h00, 8'hFF, 8'h03, 8'h0A, 8'h12, 8'h40};

    // Main sequence: reset, directed cases, abort, held start, random commands
    initial begin
        logic [7:0] c;
        bus.start_i  = 1'b0;
        bus.cmd_i    = 8'h00;
        bus.addr_i   = 32'h0;
        bus.wdata_i  = 32'h0;
        bus1.start_i = 1'b0;
        bus1.cmd_i   = 8'h00;
        bus1.addr_i  = 32'h0;
        bus1.wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_csn",   32'(bus.spi_csn_o),  32'd1);
        checkOutput("reset_sck",   32'(bus.spi_sck_o),  32'd0);
        checkOutput("reset_mosi",  32'(bus.spi_mosi_o), 32'd0);
        checkOutput("reset_busy",  32'(bus.busy_o),     32'd0);
        checkOutput("reset_done",  32'(bus.done_o),     32'd0);
        checkOutput("reset_err",   32'(bus.err_o),      32'd0);
        checkOutput("reset_rdata", bus.rdata_o,         32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed commands");
        applyStimulus("wr_reg1", 8'h11, 32'h0, 32'h0000_00A5, 32'h0);
        applyStimulus("rd_mem", 8'h0B, 32'h0000_1234, 32'h0, 32'hDEAD_BEEF);
        applyStimulus("rd_reg3", 8'h31, 32'h0, 32'h0, 32'h0000_003C);
        applyStimulus("bad_00", 8'h00, 32'h0, 32'h0, 32'h0);
        applyStimulus("bad_ff", 8'hFF, 32'h0, 32'h0, 32'h0);
        applyStimulus("wr_reg0", 8'h01, 32'h0, 32'h0000_005A, 32'h0);
        applyStimulus("wr_mem", 8'h02, 32'hCAFE_0001, 32'h1357_9BDF, 32'h0);
        applyStimulus("bad_42", 8'h42, 32'h0, 32'h0, 32'h0);

        $display("[TB] reset during address phase");
        resetMidAddr();
        applyStimulus("rd_reg0_after_rst", 8'h05, 32'h0, 32'h0, 32'h0000_0081);

        $display("[TB] held start on divide-by-one instance");
        heldStart();

        $display("[TB] random commands");
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 4) == 0) c = bad_ops[$urandom_range(0, 5)];
            else c = legal_ops[$urandom_range(0, 9)];
            applyStimulus($sformatf("rnd%0d_%02h", n, c), c, $urandom, $urandom, $urandom);
        end

        checkOutput("sck_without_cs", 32'(proto_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_host_cmd_ctrl.md
SPI_HOST_CMD_CTRL -- requirements
Module: spi_host_cmd_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2, clk_i cycles per SCK half-period, legal range 1..255.
REQ-002 Parameter DUMMY_CYCLES, default 32, SCK cycles inserted for read-mem, legal range 1..63.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  transaction request; sampled only when busy_o=0.
REQ-006 cmd_i  input  8  opcode, captured on accepted start_i.
REQ-007 addr_i  input  32  memory address, captured on accepted start_i.
REQ-008 wdata_i  input  32  write data, captured on accepted start_i; reg writes use wdata_i[7:0].
REQ-009 busy_o  output  1  transaction in progress.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  opcode rejected; valid with done_o, held until next accepted start_i.
REQ-012 rdata_o  output  32  read result; reg reads zero-extended from 8 bits; updated only at done_o.
REQ-013 spi_sck_o  output  1  SPI clock, mode 0 (idle low).
REQ-014 spi_csn_o  output  1  chip select, active-low.
REQ-015 spi_mosi_o  output  1  host-to-device serial data, MSB first.
REQ-016 spi_miso_i  input  1  device-to-host serial data, MSB first.

Function
REQ-017 Opcode table: 0x01/0x11/0x20/0x30 = write reg0..3, 8 data bits out; 0x05/0x07/0x21/0x31 = read reg0..3, 8 data bits in; 0x02 = write mem, 32 addr bits out then 32 data bits out; 0x0B = read mem, 32 addr bits out, DUMMY_CYCLES SCK cycles, 32 data bits in.
REQ-018 Any other opcode: no bus activity (CSN stays high), busy_o high for exactly 1 cycle, then done_o=1 with err_o=1; rdata_o unchanged.
REQ-019 States: IDLE, CS_SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, CS_HOLD, DONE.
REQ-020 IDLE -> CS_SETUP on start_i=1 with a legal opcode; busy_o=1 from the following cycle; err_o cleared on acceptance.
REQ-021 CS_SETUP: spi_csn_o=0, SCK low for CLK_DIV cycles; MOSI = cmd bit 7.
REQ-022 Phase order: CMD (8 bits) -> ADDR (mem only) -> DUMMY (0x0B only) -> WDATA or RDATA -> CS_HOLD.
REQ-023 Each SCK cycle = CLK_DIV clk_i cycles low then CLK_DIV high; divider counter restarts at each phase change.
REQ-024 MISO sampled on the clk_i edge that drives SCK rising; MOSI updated on the edge that drives SCK falling; first bit of each phase presented before its first rising edge.
REQ-025 MOSI = 0 during DUMMY and RDATA.
REQ-026 Bit counter counts down from phase width-1 to 0; phase advances after SCK falls following bit 0.
REQ-027 CS_HOLD: SCK low, CSN low for CLK_DIV cycles, then CSN high; DONE lasts 1 cycle: done_o=1, busy_o=0 from next cycle.
REQ-028 Read data shifts into an internal register; rdata_o loads in the DONE cycle only.
REQ-029 start_i while busy_o=1 is ignored; no queuing; start_i in the DONE cycle is ignored.
REQ-030 Bus cycle counts for CLK_DIV=D: reg access = 16 SCK; write mem = 72 SCK; read mem = 72+DUMMY_CYCLES SCK; total CSN-low time = (2*SCK+2)*D clk_i cycles.

Reset
REQ-031 rst_ni=0 at any clk_i edge forces state IDLE, spi_csn_o=1, spi_sck_o=0, spi_mosi_o=0, busy_o=0, done_o=0, err_o=0, rdata_o=0, all counters 0.
REQ-032 Reset mid-transaction aborts immediately: CSN deasserts at the reset edge, no done_o is generated.
REQ-033 First start_i honoured on the cycle after rst_ni returns high.

Verification
REQ-034 Write reg1: cmd_i=0x11, wdata_i=0xA5, D=2 -> MOSI bits 0x11 then 0xA5, 16 rising edges, CSN low 68 cycles, done_o pulse, err_o=0.
REQ-035 Read mem: cmd_i=0x0B, addr_i=0x0000_1234, device model returns 0xDEADBEEF after 32 dummy cycles -> rdata_o=0xDEADBEEF at done_o, 104 rising edges.
REQ-036 Read reg3: cmd_i=0x31, device returns 0x3C -> rdata_o=0x0000003C.
REQ-037 Illegal opcode 0x00 and 0xFF -> CSN never low, done_o 2 cycles after start, err_o=1; following legal command clears err_o.
REQ-038 Reset pulse during ADDR phase of 0x02 -> CSN high and all outputs at reset values next cycle, no done_o; subsequent 0x05 completes normally.
REQ-039 start_i held high through a 0x02 transaction and D=1 -> exactly one transaction, one done_o; second transaction starts only after start_i sampled in IDLE.
